// File: rtl/dc_bus_resp.sv
// dc_bus_resp: device-controller PIO bus slave with 16x2 register file, command/data protocol and INT1.
module dc_bus_resp #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] INT_ACK_CMD = 8'hC0
) (
    input  logic        I_CLK,
    input  logic        I_RST,
    input  logic [1:0]  I_DC_ADDR,
    input  logic        I_DC_CSF,
    input  logic        I_DC_RDF,
    input  logic        I_DC_WRF,
    input  logic [15:0] I_DC_DATA,
    output logic [15:0] O_DC_DATA,
    output logic        O_DC_DOE,
    output logic        O_DC_INT1,
    input  logic        I_INT_SET,
    input  logic        I_LD_EN,
    input  logic [3:0]  I_LD_IDX,
    input  logic        I_LD_WORD,
    input  logic [15:0] I_LD_DATA,
    output logic        O_CMD_STB,
    output logic [7:0]  O_CMD,
    output logic        O_WR_STB,
    output logic [3:0]  O_WR_IDX,
    output logic        O_WR_WORD,
    output logic [15:0] O_WR_DATA,
    output logic        O_RD_STB,
    output logic        O_ERR
);
    typedef enum logic [1:0] {IDLE, WR, RD} state_t;
    state_t      state_q, state_d;
    logic [20:0] sync_q [SYNC_STAGES];
    logic [20:0] sync_d [SYNC_STAGES];
    logic [20:0] s;
    logic [18:0] p_q, p_d;
    logic [15:0] rf_q [16][2];
    logic [15:0] rf_d [16][2];
    logic [15:0] dout_q, dout_d, wr_data_q, wr_data_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [3:0]  wr_idx_q, wr_idx_d;
    logic [1:0]  cnt_q, cnt_d, words;
    logic        doe_q, doe_d, int_q, int_d, err_q, err_d, cmd_valid_q, cmd_valid_d;
    logic        cmd_stb_q, cmd_stb_d, wr_stb_q, wr_stb_d, rd_stb_q, rd_stb_d, wr_word_q, wr_word_d;
    logic        a0_q, a0_d, rd_ok_q, rd_ok_d, ack;
    logic        access, room, wr_fall, rd_fall, wr_rise, rd_rise, csf_rise;
    logic [15:0] p_data;
    // s layout: {addr[1:0], csf, rdf, wrf, data[15:0]}; p_q holds the previous cycle's csf/rdf/wrf/data
    assign s        = sync_q[SYNC_STAGES-1];
    assign p_d      = s[18:0];
    assign p_data   = p_q[15:0];
    assign access   = !s[18] && s[20];
    assign wr_fall  = p_q[16] && !s[16];
    assign rd_fall  = p_q[17] && !s[17];
    assign wr_rise  = !p_q[16] && s[16];
    assign rd_rise  = !p_q[17] && s[17];
    assign csf_rise = !p_q[18] && s[18];
    assign words    = cmd_q[4] ? 2'd2 : 2'd1;
    assign room     = cmd_valid_q && (cnt_q < words);
    always_comb begin
        sync_d[0] = {I_DC_ADDR, I_DC_CSF, I_DC_RDF, I_DC_WRF, I_DC_DATA};
        for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    end
    always_comb begin
        state_d     = state_q;
        rf_d        = rf_q;
        dout_d      = dout_q;
        doe_d       = doe_q;
        err_d       = err_q;
        cmd_d       = cmd_q;
        cmd_valid_d = cmd_valid_q;
        cnt_d       = cnt_q;
        a0_d        = a0_q;
        rd_ok_d     = rd_ok_q;
        wr_idx_d    = wr_idx_q;
        wr_word_d   = wr_word_q;
        wr_data_d   = wr_data_q;
        cmd_stb_d   = 1'b0;
        wr_stb_d    = 1'b0;
        rd_stb_d    = 1'b0;
        ack         = 1'b0;
        // preload first so a same-cycle bus write to the same slot overrides it
        if (I_LD_EN) rf_d[I_LD_IDX][I_LD_WORD] = I_LD_DATA;
        case (state_q)
            IDLE: begin
                if (access && wr_fall && rd_fall) begin
                    err_d = 1'b1;
                end else if (access && wr_fall) begin
                    state_d = WR;
                    a0_d    = s[19];
                end else if (access && rd_fall) begin
                    state_d = RD;
                    doe_d   = 1'b1;
                    rd_ok_d = !s[19] && room;
                    dout_d  = s[19] ? {8'h00, cmd_q} : (room ? rf_q[cmd_q[3:0]][cnt_q[0]] : 16'h0000);
                    err_d   = err_q || (!s[19] && !room);
                end
            end
            WR: begin
                if (wr_rise) begin
                    state_d = IDLE;
                    if (a0_q) begin
                        cmd_d       = p_data[7:0];
                        cmd_valid_d = 1'b1;
                        cnt_d       = 2'd0;
                        cmd_stb_d   = 1'b1;
                        ack         = p_data[7:0] == INT_ACK_CMD;
                    end else if (room) begin
                        rf_d[cmd_q[3:0]][cnt_q[0]] = p_data;
                        wr_stb_d  = 1'b1;
                        wr_idx_d  = cmd_q[3:0];
                        wr_word_d = cnt_q[0];
                        wr_data_d = p_data;
                        cnt_d     = cnt_q + 2'd1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (csf_rise) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            RD: begin
                if (rd_rise || csf_rise) begin
                    state_d  = IDLE;
                    doe_d    = 1'b0;
                    rd_stb_d = rd_ok_q;
                    cnt_d    = rd_ok_q ? cnt_q + 2'd1 : cnt_q;
                end
            end
            default: state_d = IDLE;
        endcase
        int_d = I_INT_SET || (int_q && !ack);
    end
    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            state_q     <= IDLE;
            sync_q      <= '{default: '0};
            p_q         <= '0;
            rf_q        <= '{default: '{default: '0}};
            dout_q      <= '0;
            doe_q       <= 1'b0;
            int_q       <= 1'b0;
            err_q       <= 1'b0;
            cmd_q       <= '0;
            cmd_valid_q <= 1'b0;
            cnt_q       <= '0;
            a0_q        <= 1'b0;
            rd_ok_q     <= 1'b0;
            cmd_stb_q   <= 1'b0;
            wr_stb_q    <= 1'b0;
            rd_stb_q    <= 1'b0;
            wr_idx_q    <= '0;
            wr_word_q   <= 1'b0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            p_q         <= p_d;
            rf_q        <= rf_d;
            dout_q      <= dout_d;
            doe_q       <= doe_d;
            int_q       <= int_d;
            err_q       <= err_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            cnt_q       <= cnt_d;
            a0_q        <= a0_d;
            rd_ok_q     <= rd_ok_d;
            cmd_stb_q   <= cmd_stb_d;
            wr_stb_q    <= wr_stb_d;
            rd_stb_q    <= rd_stb_d;
            wr_idx_q    <= wr_idx_d;
            wr_word_q   <= wr_word_d;
            wr_data_q   <= wr_data_d;
        end
    end
    assign O_DC_DATA = dout_q;
    assign O_DC_DOE  = doe_q;
    assign O_DC_INT1 = int_q;
    assign O_CMD_STB = cmd_stb_q;
    assign O_CMD     = cmd_q;
    assign O_WR_STB  = wr_stb_q;
    assign O_WR_IDX  = wr_idx_q;
    assign O_WR_WORD = wr_word_q;
    assign O_WR_DATA = wr_data_q;
    assign O_RD_STB  = rd_stb_q;
    assign O_ERR     = err_q;
endmodule

// File: tb/tb_dc_bus_resp.sv
// tb_dc_bus_resp: scoreboard bench for dc_bus_resp driving the DC bus protocol at pin level.
module tb_dc_bus_resp;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  dc_addr = 2'b00;
    logic        dc_csf = 1'b1, dc_rdf = 1'b1, dc_wrf = 1'b1;
    logic [15:0] dc_din = '0;
    logic [15:0] dc_dout;
    logic        dc_doe, dc_int1;
    logic        int_set = 1'b0, ld_en = 1'b0, ld_word = 1'b0;
    logic [3:0]  ld_idx = '0;
    logic [15:0] ld_data = '0;
    logic        cmd_stb, wr_stb, wr_word, rd_stb, err;
    logic [7:0]  cmd;
    logic [3:0]  wr_idx;
    logic [15:0] wr_data;
    int          n_cmp = 0, n_bad = 0;
    int          n_cmd = 0, n_wr = 0, n_rd = 0;
    logic        doe_seen = 1'b0, doe_early, doe_on, doe_after;
    logic [15:0] rd_exp [$];
    logic [20:0] wr_exp [$];
    logic [15:0] got, exp_d;
    logic [20:0] exp_w;

    dc_bus_resp dut (
        .I_CLK(clk), .I_RST(rst), .I_DC_ADDR(dc_addr), .I_DC_CSF(dc_csf), .I_DC_RDF(dc_rdf),
        .I_DC_WRF(dc_wrf), .I_DC_DATA(dc_din), .O_DC_DATA(dc_dout), .O_DC_DOE(dc_doe),
        .O_DC_INT1(dc_int1), .I_INT_SET(int_set), .I_LD_EN(ld_en), .I_LD_IDX(ld_idx),
        .I_LD_WORD(ld_word), .I_LD_DATA(ld_data), .O_CMD_STB(cmd_stb), .O_CMD(cmd),
        .O_WR_STB(wr_stb), .O_WR_IDX(wr_idx), .O_WR_WORD(wr_word), .O_WR_DATA(wr_data),
        .O_RD_STB(rd_stb), .O_ERR(err)
    );

    always #10 clk = ~clk;

    // write scoreboard: every O_WR_STB must match the oldest expected write
    always @(negedge clk) begin
        if (wr_stb) begin
            n_cmp++;
            if (wr_exp.size() == 0) begin
                n_bad++;
                $display("FAIL wr_unexpected got idx=%0d word=%0d data=%h, none expected", wr_idx, wr_word, wr_data);
            end else begin
                exp_w = wr_exp.pop_front();
                if ({wr_idx, wr_word, wr_data} !== exp_w) begin
                    n_bad++;
                    $display("FAIL wr_event got %h exp %h", {wr_idx, wr_word, wr_data}, exp_w);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        if (cmd_stb) n_cmd++;
        if (wr_stb) n_wr++;
        if (rd_stb) n_rd++;
        if (dc_doe) doe_seen = 1'b1;
    endtask

    task automatic clear_counts();
        n_cmd = 0; n_wr = 0; n_rd = 0; doe_seen = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        clear_counts();
    endtask

    task automatic bus_write(input logic a1, input logic a0, input logic [15:0] d, input logic set_at_ack);
        dc_addr = {a1, a0}; dc_din = d; dc_csf = 1'b0;
        tick(); tick();
        dc_wrf = 1'b0;
        repeat (4) tick();
        dc_wrf = 1'b1;
        tick(); tick();
        int_set = set_at_ack;
        tick();
        int_set = 1'b0;
        repeat (3) tick();
        dc_csf = 1'b1;
        repeat (3) tick();
    endtask

    task automatic bus_read(input logic a1, input logic a0, output logic [15:0] d);
        dc_addr = {a1, a0}; dc_csf = 1'b0;
        tick(); tick();
        dc_rdf = 1'b0;
        tick(); tick();
        doe_early = dc_doe;
        tick();
        doe_on = dc_doe;
        d = dc_dout;
        repeat (3) tick();
        dc_rdf = 1'b1;
        repeat (4) tick();
        doe_after = dc_doe;
        dc_csf = 1'b1;
        repeat (3) tick();
    endtask

    task automatic preload(input logic [3:0] idx, input logic word, input logic [15:0] d);
        ld_en = 1'b1; ld_idx = idx; ld_word = word; ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic read_and_score(input logic a1, input logic a0, input string name);
        bus_read(a1, a0, got);
        exp_d = rd_exp.pop_front();
        n_cmp++;
        if (got !== exp_d) begin
            n_bad++;
            $display("FAIL %s got %h exp %h", name, got, exp_d);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_cmp++;
        if ({dc_dout, dc_doe, dc_int1, cmd_stb, cmd, wr_stb, wr_idx, wr_word, wr_data, rd_stb, err} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs got %h exp 0",
                     {dc_dout, dc_doe, dc_int1, cmd_stb, cmd, wr_stb, wr_idx, wr_word, wr_data, rd_stb, err});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_write();
        do_reset();
        wr_exp.push_back({4'd3, 1'b0, 16'hBEEF});
        wr_exp.push_back({4'd3, 1'b1, 16'hCAFE});
        bus_write(1'b1, 1'b1, 16'h0013, 1'b0);
        n_cmp++;
        if (n_cmd !== 1 || cmd !== 8'h13) begin
            n_bad++;
            $display("FAIL cmd_accept got stb=%0d cmd=%h exp stb=1 cmd=13", n_cmd, cmd);
        end
        bus_write(1'b1, 1'b0, 16'hBEEF, 1'b0);
        bus_write(1'b1, 1'b0, 16'hCAFE, 1'b0);
        n_cmp++;
        if (n_wr !== 2 || wr_exp.size() !== 0 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL write_pair got wr=%0d pending=%0d err=%b exp wr=2 pending=0 err=0", n_wr, wr_exp.size(), err);
        end
        bus_write(1'b1, 1'b1, 16'h0013, 1'b0);
        rd_exp.push_back(16'hBEEF);
        read_and_score(1'b1, 1'b0, "readback_w0");
        rd_exp.push_back(16'hCAFE);
        read_and_score(1'b1, 1'b0, "readback_w1");
        n_cmp++;
        if (n_rd !== 2 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL readback_strobes got rd=%0d err=%b exp rd=2 err=0", n_rd, err);
        end
    endtask

    task automatic test_read();
        do_reset();
        preload(4'd5, 1'b0, 16'h1234);
        bus_write(1'b1, 1'b1, 16'h0005, 1'b0);
        clear_counts();
        rd_exp.push_back(16'h1234);
        read_and_score(1'b1, 1'b0, "preload_read");
        n_cmp++;
        if ({doe_early, doe_on, doe_after} !== 3'b010) begin
            n_bad++;
            $display("FAIL doe_timing got early/on/after=%b%b%b exp 010", doe_early, doe_on, doe_after);
        end
        n_cmp++;
        if (n_rd !== 1 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL rd_strobe got rd=%0d err=%b exp rd=1 err=0", n_rd, err);
        end
        rd_exp.push_back(16'h0000);
        read_and_score(1'b1, 1'b0, "overrun_read");
        n_cmp++;
        if (err !== 1'b1 || n_rd !== 1) begin
            n_bad++;
            $display("FAIL overrun_err got err=%b rd=%0d exp err=1 rd=1", err, n_rd);
        end
    endtask

    task automatic test_no_cmd();
        do_reset();
        bus_write(1'b1, 1'b0, 16'h5555, 1'b0);
        n_cmp++;
        if (n_wr !== 0 || err !== 1'b1) begin
            n_bad++;
            $display("FAIL nocmd_write got wr=%0d err=%b exp wr=0 err=1", n_wr, err);
        end
        do_reset();
        bus_write(1'b1, 1'b1, 16'h001A, 1'b0);
        rd_exp.push_back(16'h001A);
        read_and_score(1'b1, 1'b1, "cmd_port_read");
        n_cmp++;
        if (err !== 1'b0 || n_rd !== 0) begin
            n_bad++;
            $display("FAIL cmd_read_side got err=%b rd=%0d exp err=0 rd=0", err, n_rd);
        end
    endtask

    task automatic test_interrupt();
        do_reset();
        int_set = 1'b1;
        tick();
        int_set = 1'b0;
        n_cmp++;
        if (dc_int1 !== 1'b1) begin
            n_bad++;
            $display("FAIL int_set got %b exp 1", dc_int1);
        end
        bus_write(1'b1, 1'b1, 16'h00C0, 1'b0);
        n_cmp++;
        if (dc_int1 !== 1'b0) begin
            n_bad++;
            $display("FAIL int_ack got %b exp 0", dc_int1);
        end
        int_set = 1'b1;
        tick();
        int_set = 1'b0;
        bus_write(1'b1, 1'b1, 16'h00C0, 1'b1);
        n_cmp++;
        if (dc_int1 !== 1'b1) begin
            n_bad++;
            $display("FAIL int_set_wins got %b exp 1", dc_int1);
        end
    endtask

    task automatic test_deselect_and_reset();
        do_reset();
        bus_write(1'b0, 1'b1, 16'h0013, 1'b0);
        bus_write(1'b0, 1'b0, 16'h1111, 1'b0);
        bus_read(1'b0, 1'b0, got);
        n_cmp++;
        if (doe_seen !== 1'b0 || n_cmd !== 0 || n_wr !== 0 || n_rd !== 0 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL deselect got doe=%b cmd=%0d wr=%0d rd=%0d err=%b exp all 0",
                     doe_seen, n_cmd, n_wr, n_rd, err);
        end
        preload(4'd5, 1'b0, 16'h1234);
        bus_write(1'b1, 1'b1, 16'h0005, 1'b0);
        dc_addr = 2'b10; dc_csf = 1'b0;
        tick(); tick();
        dc_rdf = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (dc_doe !== 1'b1) begin
            n_bad++;
            $display("FAIL pre_reset_doe got %b exp 1", dc_doe);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if (dc_doe !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_read_doe got %b exp 0", dc_doe);
        end
        repeat (3) tick();
        dc_rdf = 1'b1;
        repeat (3) tick();
        dc_csf = 1'b1;
        repeat (3) tick();
        clear_counts();
        rd_exp.push_back(16'h0000);
        read_and_score(1'b1, 1'b0, "post_reset_read");
        n_cmp++;
        if (err !== 1'b1 || n_rd !== 0) begin
            n_bad++;
            $display("FAIL post_reset_err got err=%b rd=%0d exp err=1 rd=0", err, n_rd);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_no_cmd();
        test_interrupt();
        test_deselect_and_reset();
        n_cmp++;
        if (wr_exp.size() !== 0 || rd_exp.size() !== 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain got wr=%0d rd=%0d left exp 0/0", wr_exp.size(), rd_exp.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
